// File: rtl/vga_sync_gen.sv
// VGA timing source: pixel counters, delay-matched sync/blank flags and a blanked, registered RGB output.
// Optional build macro VGA_TEST_PATTERN_EN adds an 8-bar colour test pattern selected by pattern_sel.
module vga_sync_gen #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int TICK_DIV    = 1,
  parameter int SYNC_DELAY  = 2,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        p_tick,
  output logic        video_on,
  output logic        frame_start,
  input  logic [11:0] rgb_in,
  input  logic        pattern_sel,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] rgb_out
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DLY     = (SYNC_DELAY < 1) ? 1 : SYNC_DELAY;
  localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
    $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
  end
  if (SYNC_DELAY < 0 || SYNC_DELAY > 7 || TICK_DIV < 1) begin : g_bad_cfg
    $error("vga_sync_gen: SYNC_DELAY must be 0..7 and TICK_DIV >= 1");
  end

  logic [TW-1:0]  tick_cnt_r;
  logic [TW-1:0]  tick_nxt_s;
  logic           p_tick_r;
  logic [9:0]     h_count_r;
  logic [9:0]     v_count_r;
  logic           frame_start_r;
  logic           h_end_s;
  logic           v_end_s;
  logic           vid_raw_s;
  logic           hs_raw_s;
  logic           vs_raw_s;
  logic [DLY-1:0] vid_pipe_r;
  logic [DLY-1:0] hs_pipe_r;
  logic [DLY-1:0] vs_pipe_r;
  logic [11:0]    colour_s;
  logic [11:0]    rgb_r;

  // Next tick-divider value, line/frame end detection and raw timing flags.
  always_comb begin
    tick_nxt_s = {TW{1'b0}};
    if (tick_cnt_r == TW'(TICK_DIV - 1)) begin
      tick_nxt_s = {TW{1'b0}};
    end else begin
      tick_nxt_s = tick_cnt_r + TW'(1);
    end
    h_end_s   = (h_count_r == 10'(H_TOTAL - 1));
    v_end_s   = (v_count_r == 10'(V_TOTAL - 1));
    vid_raw_s = (h_count_r < 10'(H_DISPLAY)) && (v_count_r < 10'(V_DISPLAY));
    hs_raw_s  = (h_count_r >= 10'(H_DISPLAY + H_FRONT)) &&
                (h_count_r <= 10'(H_DISPLAY + H_FRONT + H_SYNC - 1));
    vs_raw_s  = (v_count_r >= 10'(V_DISPLAY + V_FRONT)) &&
                (v_count_r <= 10'(V_DISPLAY + V_FRONT + V_SYNC - 1));
  end

  // Pixel tick divider; p_tick is held low through the reset cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      tick_cnt_r <= {TW{1'b0}};
      p_tick_r   <= 1'b0;
    end else begin
      tick_cnt_r <= tick_nxt_s;
      p_tick_r   <= (tick_nxt_s == TW'(TICK_DIV - 1));
    end
  end

  // Scan counters; frame_start marks the first cycle (0,0) is presented after a wrap.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_count_r     <= 10'd0;
      v_count_r     <= 10'd0;
      frame_start_r <= 1'b0;
    end else if (p_tick_r) begin
      frame_start_r <= h_end_s && v_end_s;
      if (h_end_s) begin
        h_count_r <= 10'd0;
        if (v_end_s) begin
          v_count_r <= 10'd0;
        end else begin
          v_count_r <= v_count_r + 10'd1;
        end
      end else begin
        h_count_r <= h_count_r + 10'd1;
      end
    end else begin
      frame_start_r <= 1'b0;
    end
  end

  // Flag delay line runs every CLK so latency is in CLK cycles, independent of TICK_DIV.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vid_pipe_r <= {DLY{1'b0}};
      hs_pipe_r  <= {DLY{1'b0}};
      vs_pipe_r  <= {DLY{1'b0}};
    end else begin
      for (int i = DLY - 1; i > 0; i--) begin
        vid_pipe_r[i] <= vid_pipe_r[i-1];
        hs_pipe_r[i]  <= hs_pipe_r[i-1];
        vs_pipe_r[i]  <= vs_pipe_r[i-1];
      end
      vid_pipe_r[0] <= vid_raw_s;
      hs_pipe_r[0]  <= hs_raw_s;
      vs_pipe_r[0]  <= vs_raw_s;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [9:0] hx_pipe_r [DLY];

  function automatic logic [11:0] bar_colour(input logic [9:0] x);
    logic [9:0] idx;
    idx = x / 10'(H_DISPLAY / 8);
    return {{4{idx[2]}}, {4{idx[1]}}, {4{idx[0]}}};
  endfunction

  // Horizontal position delayed alongside the flags so the bars line up with sync.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DLY; i++) begin
        hx_pipe_r[i] <= 10'd0;
      end
    end else begin
      for (int i = DLY - 1; i > 0; i--) begin
        hx_pipe_r[i] <= hx_pipe_r[i-1];
      end
      hx_pipe_r[0] <= h_count_r;
    end
  end

  // Visible colour source: bar pattern on request, generator colour otherwise.
  always_comb begin
    colour_s = rgb_in;
    if (pattern_sel) begin
      colour_s = bar_colour(hx_pipe_r[DLY-1]);
    end else begin
      colour_s = rgb_in;
    end
  end
`else
  logic unused_pattern_sel_s;
  assign unused_pattern_sel_s = pattern_sel;

  // Visible colour source is always the generator colour.
  always_comb begin
    colour_s = rgb_in;
  end
`endif

  // Blanked, registered connector colour.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rgb_r <= 12'h000;
    end else if (vid_pipe_r[DLY-1]) begin
      rgb_r <= colour_s;
    end else begin
      rgb_r <= 12'h000;
    end
  end

  assign pix_x       = h_count_r;
  assign pix_y       = v_count_r;
  assign p_tick      = p_tick_r;
  assign frame_start = frame_start_r;
  assign video_on    = vid_pipe_r[DLY-1];
  assign rgb_out     = rgb_r;
  assign hsync       = (SYNC_ACTIVE != 0) ? hs_pipe_r[DLY-1] : ~hs_pipe_r[DLY-1];
  assign vsync       = (SYNC_ACTIVE != 0) ? vs_pipe_r[DLY-1] : ~vs_pipe_r[DLY-1];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Randomized bench for vga_sync_gen: two reduced-timing instances (TICK_DIV 1/2, different delay
// and polarity) checked every CLK against a linear-pixel-index reference model.
module tb_vga_sync_gen;

  localparam int HD = 16, HF = 4, HS = 6, HB = 6;
  localparam int VD = 12, VF = 2, VS = 2, VB = 4;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;

  localparam int TD0 = 1, SD0 = 2, SA0 = 0;
  localparam int TD1 = 2, SD1 = 0, SA1 = 1;

  logic        CLK;
  logic        RESET;
  logic [11:0] rgb_in;
  logic        pattern_sel;

  logic [9:0]  ax, ay, bx, by;
  logic        ap, av, af, ahs, avs;
  logic        bp, bv, bf, bhs, bvs;
  logic [11:0] argb, brgb;

  int n_checks = 0;
  int n_errors = 0;

  int   k_m      [2];
  int   ticks_m  [2];
  int   hist_m   [2][8];
  logic p_last_m [2];
  logic vid_prev_m [2];
  int   hx_prev_m [2];
  int   mx [2];
  int   my [2];

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .TICK_DIV(TD0), .SYNC_DELAY(SD0), .SYNC_ACTIVE(SA0)
  ) u_dut_a (
    .CLK(CLK), .RESET(RESET), .pix_x(ax), .pix_y(ay), .p_tick(ap), .video_on(av),
    .frame_start(af), .rgb_in(rgb_in), .pattern_sel(pattern_sel),
    .hsync(ahs), .vsync(avs), .rgb_out(argb)
  );

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .TICK_DIV(TD1), .SYNC_DELAY(SD1), .SYNC_ACTIVE(SA1)
  ) u_dut_b (
    .CLK(CLK), .RESET(RESET), .pix_x(bx), .pix_y(by), .p_tick(bp), .video_on(bv),
    .frame_start(bf), .rgb_in(rgb_in), .pattern_sel(pattern_sel),
    .hsync(bhs), .vsync(bvs), .rgb_out(brgb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected visible colour for a given (delayed) horizontal position.
  function automatic int exp_colour(input int hx);
    int b;
    b = hx / (HD / 8);
`ifdef VGA_TEST_PATTERN_EN
    if (pattern_sel) begin
      return (b[2] ? 32'hF00 : 32'h0) | (b[1] ? 32'h0F0 : 32'h0) | (b[0] ? 32'h00F : 32'h0);
    end
`endif
    return int'(rgb_in);
  endfunction

  // Reference model: pixel index = ticks since reset; position, flags and colour derived arithmetically.
  task automatic step(input int i, input int td, input int sd, input int sa,
                      input logic [9:0] ox, input logic [9:0] oy, input logic op,
                      input logic ov, input logic ofs, input logic ohs, input logic ovs,
                      input logic [11:0] orgb);
    int pos, x, y, lat, dp, hx, dx, dy, erg;
    logic pe, vid, hs, vs, fs;
    string n;
    n = (i == 0) ? "A" : "B";
    if (RESET) begin
      k_m[i] = 0;
      ticks_m[i] = 0;
    end else begin
      if (p_last_m[i]) ticks_m[i]++;
      k_m[i]++;
    end
    for (int j = 7; j > 0; j--) hist_m[i][j] = hist_m[i][j-1];
    hist_m[i][0] = ticks_m[i];
    pos = ticks_m[i];
    x = pos % HT;
    y = (pos / HT) % VT;
    pe = (k_m[i] >= 1) && (k_m[i] % td == td - 1);
    lat = (sd < 1) ? 1 : sd;
    vid = 1'b0; hs = 1'b0; vs = 1'b0; hx = 0;
    if (k_m[i] >= lat) begin
      dp  = hist_m[i][lat];
      dx  = dp % HT;
      dy  = (dp / HT) % VT;
      hx  = dx;
      vid = (dx < HD) && (dy < VD);
      hs  = (dx >= HD + HF) && (dx < HD + HF + HS);
      vs  = (dy >= VD + VF) && (dy < VD + VF + VS);
    end
    fs = (k_m[i] >= 1) && (pos > 0) && (pos % (HT * VT) == 0) && (hist_m[i][1] != pos);
    erg = 0;
    if (!RESET && vid_prev_m[i]) erg = exp_colour(hx_prev_m[i]);
    chk({n, ".pix_x"}, int'(ox), x);
    chk({n, ".pix_y"}, int'(oy), y);
    chk({n, ".p_tick"}, int'(op), int'(pe));
    chk({n, ".video_on"}, int'(ov), int'(vid));
    chk({n, ".frame_start"}, int'(ofs), int'(fs));
    chk({n, ".hsync"}, int'(ohs), (sa != 0) ? int'(hs) : int'(!hs));
    chk({n, ".vsync"}, int'(ovs), (sa != 0) ? int'(vs) : int'(!vs));
    chk({n, ".rgb_out"}, int'(orgb), erg);
    p_last_m[i]   = pe;
    vid_prev_m[i] = vid;
    hx_prev_m[i]  = hx;
    mx[i] = x;
    my[i] = y;
  endtask

  task automatic cycle(input logic rst);
    RESET       = rst;
    rgb_in      = 12'($urandom);
    pattern_sel = 1'($urandom);
    @(negedge CLK);
    step(0, TD0, SD0, SA0, ax, ay, ap, av, af, ahs, avs, argb);
    step(1, TD1, SD1, SA1, bx, by, bp, bv, bf, bhs, bvs, brgb);
  endtask

  initial begin
    int found;
    RESET = 1'b1;
    rgb_in = 12'h000;
    pattern_sel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      k_m[i] = 0; ticks_m[i] = 0; p_last_m[i] = 1'b0;
      vid_prev_m[i] = 1'b0; hx_prev_m[i] = 0; mx[i] = 0; my[i] = 0;
      for (int j = 0; j < 8; j++) hist_m[i][j] = 0;
    end

    repeat (3) cycle(1'b1);
    repeat (2 * HT * VT * TD1 + 150) cycle(1'b0);

    for (int r = 0; r < 15; r++) begin
      repeat ($urandom_range(700, 40)) cycle(1'b0);
      repeat ($urandom_range(3, 1)) cycle(1'b1);
    end

    // Reset landing inside both hsync and vsync of instance A.
    found = 0;
    for (int n = 0; n < 2 * HT * VT && found == 0; n++) begin
      cycle(1'b0);
      if (mx[0] == HD + HF + 2 && my[0] == VD + VF) found = 1;
    end
    chk("A.reach_sync_point", found, 1);
    cycle(1'b1);
    repeat (HT * VT * TD1 + 100) cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Timing source for the VGA display path. Produces the pixel scan coordinates (pix_x, pix_y) that the text/graphics generators consume, and the hsync/vsync/blanking signals for the connector.
- Accepts the generators' 12-bit colour back and drives the connector RGB with blanking applied.
- Sync signals are delay-matched to the generators' pipeline latency.
- Default timing: 640x480 at 60 Hz, with a 25 MHz pixel rate derived from CLK.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- TICK_DIV, 1, CLK cycles per pixel (1 = CLK is the pixel clock; 2 = 50 MHz CLK)
- SYNC_DELAY, 2, CLK cycles of delay on hsync/vsync/video_on to match generator latency (0..7)
- SYNC_ACTIVE, 0, sync pulse polarity (0 = active low)

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- pix_x  out  10  current horizontal count (0..H_TOTAL-1)
- pix_y  out  10  current vertical count (0..V_TOTAL-1)
- p_tick  out  1  one-CLK pulse marking each pixel advance
- video_on  out  1  visible-area flag, delayed by SYNC_DELAY
- frame_start  out  1  one-CLK pulse when pix_x=0 and pix_y=0 are first presented
- rgb_in  in  12  colour from the generator (graph_rgb)
- pattern_sel  in  1  test-pattern request (see Optional Feature)
- hsync  out  1  horizontal sync to connector, delayed
- vsync  out  1  vertical sync to connector, delayed
- rgb_out  out  12  connector colour, registered, forced to 0 when blanked

Behaviour:
- Derived totals: H_TOTAL = sum of the H parameters (800); V_TOTAL = sum of the V parameters (525).
- Tick counter:
  - Counts 0..TICK_DIV-1, wraps to 0.
  - p_tick = 1 on the cycle the counter equals TICK_DIV-1.
  - With TICK_DIV=1, p_tick is constantly 1 after reset.
- h_count:
  - On p_tick, increments; at H_TOTAL-1 it wraps to 0.
  - v_count increments on the same p_tick as the wrap; v_count at V_TOTAL-1 wraps to 0 together with h_count.
- pix_x/pix_y are the registered h_count/v_count, with no added delay. They are stable between ticks.
- Raw flags, computed from the counters:
  - vid_raw = (h < H_DISPLAY) && (v < V_DISPLAY).
  - hs_raw active for h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1], i.e. 656..751.
  - vs_raw active for v in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], i.e. 490..491.
- Delay line:
  - hs_raw, vs_raw and vid_raw pass through a SYNC_DELAY-stage shift register clocked every CLK, not gated by p_tick.
  - With SYNC_DELAY=0 the raw flags are registered once (1-cycle latency).
  - hsync/vsync output level = SYNC_ACTIVE when active, ~SYNC_ACTIVE otherwise.
- rgb_out: registered each CLK = video_on ? rgb_in : 12'h000. There is never non-zero colour outside the visible area.
- frame_start: asserted for exactly one CLK, on the p_tick cycle in which the counters transition to (0,0).
- Reset (synchronous, checked every CLK, overrides everything):
  - All counters and delay stages clear to 0.
  - pix_x=0, pix_y=0, video_on=0, rgb_out=0, p_tick=0, frame_start=0.
  - hsync=vsync=~SYNC_ACTIVE (inactive).
- Reset asserted mid-line or mid-frame: the next cycle after deassertion starts a fresh frame at (0,0). No partial sync pulse may survive reset.
- First frame after reset: frame_start is not asserted for the reset state; the first pulse comes at the first wrap to (0,0).
- Widths: counters are 10 bits. Parameter combinations with H_TOTAL or V_TOTAL > 1024 are illegal. Flag them with an elaboration-time check.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN
- Defined: when pattern_sel=1, rgb_out in the visible area is replaced by 8 vertical colour bars, each H_DISPLAY/8 wide (80 px). Bar k (k = pix_x/80) has colour {R,G,B} nibbles = {k[2]?F:0, k[1]?F:0, k[0]?F:0}.
  - The bar index is taken from the delayed pix_x, so the bars align with the sync outputs.
  - Blanking still forces 0.
- Undefined: pattern_sel is ignored; rgb_out depends only on rgb_in and video_on.

Test Plan:
- Free-run with TICK_DIV=1, SYNC_DELAY=2, RESET pulsed for 3 cycles -> hsync period 800 CLK with low width 96; the falling edge lands 656+2 CLK after the h=0 cycle; vsync low for exactly 2 lines (1600 CLK) once per 420000 CLK; frame_start once per 420000 CLK.
- rgb_in held at 12'hABC -> rgb_out=12'hABC only while video_on=1, and 0 during pix_x 640..799 and pix_y 480..524; count 307200 non-zero pixels per frame.
- TICK_DIV=2 -> p_tick high every other CLK; pix_x holds each value for 2 CLK; hsync period 1600 CLK.
- Assert RESET at pix_x=700, pix_y=490 (inside vsync) -> the next cycle shows hsync=vsync=1 and rgb_out=0; after release the counters restart at (0,0) and vsync stays high until v=490.
- pix_x/pix_y wrap: observe (799,524) -> (0,0) with frame_start=1 on that tick, and (799,10) -> (0,11).
- With VGA_TEST_PATTERN_EN, pattern_sel=1 -> at visible pix_x=0..79 rgb_out=000, at 80..159 rgb_out=00F, ..., at 560..639 rgb_out=FFF; with pattern_sel=0, rgb_out=rgb_in.
